// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
// Holds the FSM state encoding, its width, default timing and a width helper.
package stopwatch_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_CLK_HZ     = 50_000_000;
    localparam int DEF_TICK_HZ    = 1;
    localparam int DEF_DEB_CYCLES = 1_000_000;

    // Bits needed to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one push button.
// Ports: FPGA_clock, reset (async, active-low), raw (async button),
// level (debounced), press (one-cycle pulse on debounced rising edge).
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic FPGA_clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Level flips on the DEB_CYCLES-th consecutive differing sample.
    always_ff @(posedge FPGA_clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons, tick divider and run/pause/lap/alarm FSM.
// Ports: FPGA_clock, reset, btn_start/lap/dir, cnt_val in; tick_en, cnt_clr,
// up_down, lap_hold, state, alarm out (all registered).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int TICK_HZ    = DEF_TICK_HZ,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic               FPGA_clock,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               btn_lap,
    input  logic               btn_dir,
    input  logic [3:0]         cnt_val,
    output logic               tick_en,
    output logic               cnt_clr,
    output logic               up_down,
    output logic               lap_hold,
    output logic [STATE_W-1:0] state,
    output logic               alarm
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = cnt_width(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [2:0] unused_levels;
    logic       p_start;
    logic       p_lap;
    logic       p_dir;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .FPGA_clock (FPGA_clock),
        .reset      (reset),
        .raw        (btn_start),
        .level      (unused_levels[0]),
        .press      (p_start)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .FPGA_clock (FPGA_clock),
        .reset      (reset),
        .raw        (btn_lap),
        .level      (unused_levels[1]),
        .press      (p_lap)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .FPGA_clock (FPGA_clock),
        .reset      (reset),
        .raw        (btn_dir),
        .level      (unused_levels[2]),
        .press      (p_dir)
    );

    state_t        st_q, st_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;
    logic          clr_q, clr_d;
    logic          up_q, up_d;
    logic          lap_q, lap_d;
    logic          alarm_q, alarm_d;

    logic ev_start;
    logic ev_lap;
    logic wrap;
    logic term;

    // Start beats lap when both arrive together.
    assign ev_start = p_start;
    assign ev_lap   = p_lap & ~p_start;
    assign wrap     = (div_q == DIV_LAST);
    assign term     = wrap & ~up_q & (cnt_val == 4'd0);

    always_ff @(posedge FPGA_clock or negedge reset) begin
        if (!reset) begin
            st_q    <= ST_IDLE;
            div_q   <= '0;
            tick_q  <= 1'b0;
            clr_q   <= 1'b0;
            up_q    <= 1'b1;
            lap_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            clr_q   <= clr_d;
            up_q    <= up_d;
            lap_q   <= lap_d;
            alarm_q <= alarm_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        clr_d   = 1'b0;
        up_d    = up_q;
        lap_d   = lap_q;
        alarm_d = alarm_q;
        unique case (st_q)
            ST_IDLE: begin
                if (ev_start) st_d = ST_RUN;
                if (p_dir)    up_d = ~up_q;
            end
            ST_RUN: begin
                div_d = wrap ? '0 : div_q + 1'b1;
                // Countdown hit zero: swallow the tick and raise the alarm.
                if (term) begin
                    st_d    = ST_DONE;
                    alarm_d = 1'b1;
                end else begin
                    tick_d = wrap;
                    if (ev_start)    st_d  = ST_PAUSE;
                    else if (ev_lap) lap_d = ~lap_q;
                end
            end
            ST_PAUSE: begin
                if (ev_start) begin
                    st_d = ST_RUN;
                end else if (ev_lap) begin
                    st_d  = ST_IDLE;
                    clr_d = 1'b1;
                    div_d = '0;
                    lap_d = 1'b0;
                end
                if (p_dir) up_d = ~up_q;
            end
            ST_DONE: begin
                if (ev_start | ev_lap) begin
                    st_d    = ST_IDLE;
                    clr_d   = 1'b1;
                    div_d   = '0;
                    lap_d   = 1'b0;
                    alarm_d = 1'b0;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    assign tick_en  = tick_q;
    assign cnt_clr  = clr_q;
    assign up_down  = up_q;
    assign lap_hold = lap_q;
    assign state    = st_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a small clock and debounce.
// Behavioural model compared every cycle, plus directed latency checks.
module tb_stopwatch_ctrl;

    localparam int DIV = 10;
    localparam int DEB = 4;

    localparam int W_STATE = 0;
    localparam int W_UP    = 1;
    localparam int W_LAP   = 2;
    localparam int W_CLR   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_dir = 1'b0;
    logic [3:0] cnt_val = 4'd5;
    logic       tick_en;
    logic       cnt_clr;
    logic       up_down;
    logic       lap_hold;
    logic [1:0] state;
    logic       alarm;

    int errors = 0;
    int checks = 0;

    stopwatch_ctrl #(
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .DEB_CYCLES (DEB)
    ) dut (
        .FPGA_clock (clk),
        .reset      (rst_n),
        .btn_start  (btn_start),
        .btn_lap    (btn_lap),
        .btn_dir    (btn_dir),
        .cnt_val    (cnt_val),
        .tick_en    (tick_en),
        .cnt_clr    (cnt_clr),
        .up_down    (up_down),
        .lap_hold   (lap_hold),
        .state      (state),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state = 0;
    int m_run   = 0;
    bit m_tick  = 0;
    bit m_clr   = 0;
    bit m_up    = 1;
    bit m_lap   = 0;
    bit m_alarm = 0;
    bit dly0[3];
    bit dly1[3];
    bit lvl[3];
    int stable[3];
    bit pe[3];
    bit ms, ml, md, term, seen;
    bit [2:0] rawv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_run = 0; m_tick = 0; m_clr = 0;
            m_up = 1; m_lap = 0; m_alarm = 0;
            for (int b = 0; b < 3; b++) begin
                dly0[b] = 0; dly1[b] = 0; lvl[b] = 0;
                stable[b] = 0; pe[b] = 0;
            end
        end else begin
            ms = pe[0];
            ml = pe[1] & ~pe[0];
            md = pe[2];
            m_tick = 0;
            m_clr  = 0;
            case (m_state)
                0: begin
                    if (ms) m_state = 1;
                    if (md) m_up = !m_up;
                end
                1: begin
                    term = 0;
                    m_run++;
                    if (m_run == DIV) begin
                        m_run = 0;
                        term = !m_up && (cnt_val == 0);
                        m_tick = !term;
                    end
                    if (term) begin
                        m_state = 3;
                        m_alarm = 1;
                    end else if (ms) m_state = 2;
                    else if (ml) m_lap = !m_lap;
                end
                2: begin
                    if (ms) m_state = 1;
                    else if (ml) begin
                        m_clr = 1; m_run = 0; m_lap = 0; m_state = 0;
                    end
                    if (md) m_up = !m_up;
                end
                default: begin
                    if (ms || ml) begin
                        m_clr = 1; m_alarm = 0; m_lap = 0; m_state = 0;
                    end
                end
            endcase
            // Button seen two samples late, then needs DEB differing samples.
            rawv = {btn_dir, btn_lap, btn_start};
            for (int b = 0; b < 3; b++) begin
                seen = dly1[b];
                dly1[b] = dly0[b];
                dly0[b] = rawv[b];
                pe[b] = 0;
                if (seen != lvl[b]) begin
                    stable[b]++;
                    if (stable[b] == DEB) begin
                        lvl[b] = seen;
                        stable[b] = 0;
                        pe[b] = seen;
                    end
                end else stable[b] = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("tick_en", tick_en, m_tick);
        chk("cnt_clr", cnt_clr, m_clr);
        chk("up_down", up_down, m_up);
        chk("lap_hold", lap_hold, m_lap);
        chk("state", state, m_state);
        chk("alarm", alarm, m_alarm);
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] watched(input int w);
        case (w)
            W_STATE: return 32'(state);
            W_UP:    return 32'(up_down);
            W_LAP:   return 32'(lap_hold);
            default: return 32'(cnt_clr);
        endcase
    endfunction

    task automatic press_wait(input logic [2:0] btns, input int w,
                              output int n, output int clr_n);
        logic [31:0] v0;
        v0 = watched(w);
        n = 0;
        clr_n = 0;
        if (btns[0]) btn_start = 1'b1;
        if (btns[1]) btn_lap = 1'b1;
        if (btns[2]) btn_dir = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cnt_clr) clr_n++;
            if (watched(w) != v0) begin
                n = i;
                break;
            end
        end
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        btn_dir   = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tick_en === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int n, c, tk;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst state", state, 0);
        chk("rst up_down", up_down, 1);
        chk("rst tick", tick_en, 0);
        chk("rst clr", cnt_clr, 0);
        chk("rst alarm", alarm, 0);
        rst_n = 1'b1;
        settle(2);

        // Short glitches never make it through.
        repeat (5) begin
            btn_start = 1'b1;
            settle(2);
            btn_start = 1'b0;
            settle(3);
        end
        settle(10);
        chk("glitch state", state, 0);

        // Clean start, first and second tick spacing.
        press_wait(3'b001, W_STATE, n, c);
        chk("start latency", n, 7);
        chk("start state", state, 1);
        wait_tick(n);
        chk("first tick", n, 10);
        @(negedge clk);
        chk("tick width", tick_en, 0);
        wait_tick(n);
        chk("tick period", n, 9);

        // 13 cycles of RUN, pause, resume keeps phase.
        settle(6);
        press_wait(3'b001, W_STATE, n, c);
        chk("pause state", state, 2);
        settle(20);
        press_wait(3'b001, W_STATE, n, c);
        chk("resume state", state, 1);
        wait_tick(n);
        chk("resume tick", n, 7);

        // Lap toggles in RUN.
        press_wait(3'b010, W_LAP, n, c);
        chk("lap latency", n, 7);
        chk("lap on", lap_hold, 1);
        settle(8);
        press_wait(3'b010, W_LAP, n, c);
        chk("lap off", lap_hold, 0);
        settle(8);
        press_wait(3'b010, W_LAP, n, c);
        chk("lap on again", lap_hold, 1);
        settle(8);

        // Pause then clear.
        press_wait(3'b001, W_STATE, n, c);
        chk("pause2 state", state, 2);
        settle(8);
        press_wait(3'b010, W_CLR, n, c);
        chk("clear latency", n, 7);
        chk("clear state", state, 0);
        chk("clear lap", lap_hold, 0);
        @(negedge clk);
        chk("clear width", cnt_clr, 0);
        settle(8);
        press_wait(3'b001, W_STATE, n, c);
        wait_tick(n);
        chk("tick after clear", n, 10);

        // Countdown to zero.
        press_wait(3'b001, W_STATE, n, c);
        settle(8);
        press_wait(3'b010, W_CLR, n, c);
        settle(8);
        press_wait(3'b100, W_UP, n, c);
        chk("dir latency", n, 7);
        chk("dir down", up_down, 0);
        settle(8);
        cnt_val = 4'd0;
        press_wait(3'b001, W_STATE, n, c);
        chk("down run", state, 1);
        n = 0;
        tk = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tick_en) tk++;
            if (state == 2'd3) begin
                n = i;
                break;
            end
        end
        chk("done latency", n, 10);
        chk("done ticks", tk, 0);
        chk("done alarm", alarm, 1);
        settle(8);
        chk("alarm held", alarm, 1);
        press_wait(3'b001, W_CLR, n, c);
        chk("done clear", n, 7);
        chk("done idle", state, 0);
        chk("alarm off", alarm, 0);
        @(negedge clk);
        chk("done clr width", cnt_clr, 0);

        // Start and lap together in PAUSE.
        cnt_val = 4'd5;
        settle(8);
        press_wait(3'b100, W_UP, n, c);
        chk("dir up", up_down, 1);
        settle(8);
        press_wait(3'b001, W_STATE, n, c);
        settle(8);
        press_wait(3'b001, W_STATE, n, c);
        chk("pause3 state", state, 2);
        settle(8);
        press_wait(3'b011, W_STATE, n, c);
        chk("both latency", n, 7);
        chk("both state", state, 1);
        chk("both no clr", c, 0);
        settle(8);
        press_wait(3'b010, W_LAP, n, c);
        chk("lap before rst", lap_hold, 1);
        settle(3);

        // Asynchronous reset mid-divide and mid-debounce.
        btn_start = 1'b1;
        settle(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async state", state, 0);
        chk("async lap", lap_hold, 0);
        chk("async tick", tick_en, 0);
        chk("async up", up_down, 1);
        btn_start = 1'b0;
        settle(3);
        rst_n = 1'b1;
        settle(20);
        chk("post rst state", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
